ccip_rd_arbiter: RTL and testbench
==================================

Name: ccip_rd_arbiter

Overview:
Round-robin arbiter that shares the CCI-P c0 memory read-request channel among NUM_REQ internal requesters. It sits between the AFU's DMA engines and the registered CCI-P Tx/Rx ports, alongside the MMIO responder. It tags each request's mdata with the requester index and tracks per-requester outstanding reads. It routes read responses back to their originator and honours c0TxAlmFull.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
MAX_OUTSTANDING, 16, max in-flight reads per requester (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester read request valid
req_addr  in  NUM_REQ*42  per-requester cache-line address; requester i at [42*i+41:42*i]
req_ready  out  NUM_REQ  per-requester accept (combinational)
c0_tx_almfull  in  1  CCI-P c0TxAlmFull
c0_tx_valid  out  1  read request valid to CCI-P c0
c0_tx_addr  out  42  request address
c0_tx_mdata  out  16  request mdata
c0_rx_rd_valid  in  1  read response valid (rspValid and resp_type = read)
c0_rx_mdata  in  16  response mdata
c0_rx_data  in  512  response data
rsp_valid  out  NUM_REQ  one-hot response strobe
rsp_data  out  512  response data, shared
outstanding_any  out  1  any requester has a nonzero outstanding count
err_sticky  out  1  bad response seen; cleared only by rst
stat_issued  out  32  total requests issued (feature)
stat_stall  out  32  almfull-stalled cycles (feature)

Behaviour:
- Reset (rst=1, asynchronous): all outputs 0, rr_ptr=0, all outstanding counters 0, err_sticky=0, stat counters 0.
- Reset mid-operation discards all state. The host must be quiesced first. Late responses after reset are handled by the error rule below.
- Eligibility: requester i is eligible when req_valid[i]=1 and outst[i] < MAX_OUTSTANDING.
- Grant: at most one per cycle, and only when c0_tx_almfull=0.
  - Select the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[grant]=1 in that same cycle; all other req_ready bits are 0.
  - After a grant, rr_ptr <= (grant+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Request output is registered, one-cycle latency:
  - Next cycle: c0_tx_valid=1, c0_tx_addr=req_addr[grant], c0_tx_mdata={zeros, grant index in low ceil(log2 NUM_REQ) bits}.
  - With no grant, c0_tx_valid=0; addr and mdata hold.
- Response path:
  - On c0_rx_rd_valid, id = c0_rx_mdata low bits.
  - Next cycle: rsp_valid[id]=1 (single cycle) and rsp_data=c0_rx_data.
  - outst[id] decrements.
- Response errors, when id >= NUM_REQ, c0_rx_mdata upper bits are nonzero, or outst[id]=0:
  - The response is dropped: no rsp_valid, counter unchanged.
  - err_sticky <= 1.
- Simultaneous grant and valid response on the same requester: outst unchanged.
- Counter widths are 8 bits and never overflow, because eligibility blocks at MAX_OUTSTANDING.
- outstanding_any is registered; it is the OR of all outst != 0 as of the previous edge.
- Responses are accepted unconditionally; there is no backpressure on the Rx side.

Optional Feature:
Macro CCIP_RD_ARBITER_STATS_EN.
- Defined:
  - stat_issued increments by 1 on each grant.
  - stat_stall increments on each cycle with c0_tx_almfull=1 and any req_valid=1.
  - Both are 32-bit, wrap modulo 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are present.

Decomposition:
- Package ccip_rd_arb_pkg holds:
  - constants CL_ADDR_W=42, MDATA_W=16, CL_DATA_W=512, OUTST_W=8
  - function clog2_req
  - typedef t_req_id
- Sub-module rr_arbiter (parameter N): pure combinational rotate-priority pick.
  - Inputs: eligible vector, ptr.
  - Outputs: grant_valid, grant_idx.
- The pointer and all counters live in ccip_rd_arbiter.

Test Plan:
- Only req_valid[0]=1, addr 0x123, almfull=0: req_ready[0]=1 the same cycle; next cycle c0_tx_valid=1, addr 0x123, mdata 0x0000.
- All 4 req_valid held high for 8 cycles, no almfull: grant order is 0,1,2,3,0,1,2,3 with mdata 0,1,2,3,...
- almfull=1 for 5 cycles with req 2 and 3 valid, rr_ptr=2: no req_ready, no tx. Deassert: req 2 is granted first, then 3.
- MAX_OUTSTANDING=2, req 1 issues 2 reads and its third stalls. Response mdata=0x0001 with data 0xAB..: next cycle rsp_valid=4'b0010 and rsp_data matches; the stalled request is then accepted.
- Response mdata=0x0007 (NUM_REQ=4), then a response with mdata=0 while outst[0]=0: no rsp_valid, err_sticky=1 and held until rst.
- Req 0 granted in the same cycle as a response for req 0 with outst[0]=3: outst[0] stays 3. With STATS_EN, stat_issued increments by exactly 1 per grant.

Source files
------------

// File: rtl/ccip_rd_arb_pkg.sv
// Shared constants, types and helpers for the CCI-P c0 read arbiter.
// Macro CCIP_RD_ARBITER_STATS_EN (in the top) enables statistics counters.
package ccip_rd_arb_pkg;

  localparam int CL_ADDR_W  = 42;
  localparam int MDATA_W    = 16;
  localparam int CL_DATA_W  = 512;
  localparam int OUTST_W    = 8;
  localparam int REQ_ID_W   = 4;

  // Wide enough for up to 16 requesters
  typedef logic [REQ_ID_W-1:0] t_req_id;

  // Index width for n requesters, never less than 1
  function automatic int clog2_req(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: first eligible index at or after ptr.
// Ports: eligible (N), ptr (index) -> grant_valid, grant_idx.
module rr_arbiter
  import ccip_rd_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]               eligible,
  input  logic [clog2_req(N)-1:0]    ptr,
  output logic                       grant_valid,
  output logic [clog2_req(N)-1:0]    grant_idx
);

  localparam int IW = clog2_req(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Doubling the vector turns the wrap-around search into a plain shift
  assign dbl = {eligible, eligible};
  assign rot = N'(dbl >> ptr);

  // Walk from far to near so the nearest eligible index wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/ccip_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 read channel among NUM_REQ
// requesters; tags mdata with the requester id, tracks per-requester
// outstanding reads and routes responses back.
// Ports: clk/rst; req_valid/req_addr/req_ready (requesters);
// c0_tx_* (request out); c0_rx_* (response in); rsp_valid/rsp_data;
// outstanding_any, err_sticky; stat_issued/stat_stall.
// Macro CCIP_RD_ARBITER_STATS_EN enables stat_issued/stat_stall counters.
module ccip_rd_arbiter
  import ccip_rd_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*CL_ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         c0_tx_almfull,
  output logic                         c0_tx_valid,
  output logic [CL_ADDR_W-1:0]         c0_tx_addr,
  output logic [MDATA_W-1:0]           c0_tx_mdata,
  input  logic                         c0_rx_rd_valid,
  input  logic [MDATA_W-1:0]           c0_rx_mdata,
  input  logic [CL_DATA_W-1:0]         c0_rx_data,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [CL_DATA_W-1:0]         rsp_data,
  output logic                         outstanding_any,
  output logic                         err_sticky,
  output logic [31:0]                  stat_issued,
  output logic [31:0]                  stat_stall
);

  localparam int IW = clog2_req(NUM_REQ);
  localparam logic [OUTST_W-1:0] OUTST_MAX =
    OUTST_W'(MAX_OUTSTANDING);

  logic [IW-1:0]        rr_ptr;
  logic [OUTST_W-1:0]   outst [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible;
  logic                 grant_valid;
  logic                 grant_fire;
  logic [IW-1:0]        grant_idx;
  logic [IW-1:0]        ptr_next;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [CL_ADDR_W-1:0] grant_addr;
  t_req_id              rx_id;
  logic                 rx_hi_zero;
  logic                 rx_cnt_nz;
  logic                 rx_ok;
  logic [NUM_REQ-1:0]   rx_oh;
  logic                 any_nz;

  always_comb begin
    eligible = '0;
    any_nz   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] & (outst[i] < OUTST_MAX);
      any_nz      = any_nz | (outst[i] != '0);
    end
  end

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .eligible    (eligible),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // No grants while held in reset so req_ready reads 0
  assign grant_fire = grant_valid & ~c0_tx_almfull & ~rst;

  always_comb begin
    grant_oh   = '0;
    grant_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IW'(i)) begin
        grant_oh[i] = grant_fire;
        grant_addr  = req_addr[i*CL_ADDR_W +: CL_ADDR_W];
      end
    end
  end

  assign req_ready = grant_oh;
  assign ptr_next  = (grant_idx == IW'(NUM_REQ - 1)) ?
                     '0 : grant_idx + 1'b1;

  // Response decode; rx_oh stays empty when the id is out of range
  assign rx_id      = t_req_id'(c0_rx_mdata[IW-1:0]);
  assign rx_hi_zero = (c0_rx_mdata[MDATA_W-1:IW] == '0);

  always_comb begin
    rx_oh     = '0;
    rx_cnt_nz = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rx_id == t_req_id'(i)) begin
        rx_oh[i]  = 1'b1;
        rx_cnt_nz = (outst[i] != '0);
      end
    end
  end

  assign rx_ok = c0_rx_rd_valid & rx_hi_zero & rx_cnt_nz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr          <= '0;
      c0_tx_valid     <= 1'b0;
      c0_tx_addr      <= '0;
      c0_tx_mdata     <= '0;
      rsp_valid       <= '0;
      rsp_data        <= '0;
      outstanding_any <= 1'b0;
      err_sticky      <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        outst[i] <= '0;
      end
    end else begin
      c0_tx_valid <= grant_fire;
      if (grant_fire) begin
        rr_ptr      <= ptr_next;
        c0_tx_addr  <= grant_addr;
        c0_tx_mdata <= MDATA_W'(grant_idx);
      end
      rsp_valid <= rx_ok ? rx_oh : '0;
      if (rx_ok) begin
        rsp_data <= c0_rx_data;
      end
      if (c0_rx_rd_valid && !rx_ok) begin
        err_sticky <= 1'b1;
      end
      outstanding_any <= any_nz;
      // Grant and response on the same requester cancel out
      for (int i = 0; i < NUM_REQ; i++) begin
        unique case ({grant_oh[i], rx_ok & rx_oh[i]})
          2'b10:   outst[i] <= outst[i] + 1'b1;
          2'b01:   outst[i] <= outst[i] - 1'b1;
          default: outst[i] <= outst[i];
        endcase
      end
    end
  end

`ifdef CCIP_RD_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (grant_fire) begin
        stat_issued <= stat_issued + 32'd1;
      end
      if (c0_tx_almfull && (|req_valid)) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`else
  assign stat_issued = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_ccip_rd_arbiter.sv
// Scoreboard bench for ccip_rd_arbiter (NUM_REQ=4, MAX_OUTSTANDING=4).
// Directed stimulus pushes expectations; a negedge monitor pops them.
module tb_ccip_rd_arbiter;

  localparam int NR = 4;
  localparam int MO = 4;

  logic           clk;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*42-1:0] req_addr;
  logic [NR-1:0]  req_ready;
  logic           c0_tx_almfull;
  logic           c0_tx_valid;
  logic [41:0]    c0_tx_addr;
  logic [15:0]    c0_tx_mdata;
  logic           c0_rx_rd_valid;
  logic [15:0]    c0_rx_mdata;
  logic [511:0]   c0_rx_data;
  logic [NR-1:0]  rsp_valid;
  logic [511:0]   rsp_data;
  logic           outstanding_any;
  logic           err_sticky;
  logic [31:0]    stat_issued;
  logic [31:0]    stat_stall;

  ccip_rd_arbiter #(
    .NUM_REQ(NR),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_ready       (req_ready),
    .c0_tx_almfull   (c0_tx_almfull),
    .c0_tx_valid     (c0_tx_valid),
    .c0_tx_addr      (c0_tx_addr),
    .c0_tx_mdata     (c0_tx_mdata),
    .c0_rx_rd_valid  (c0_rx_rd_valid),
    .c0_rx_mdata     (c0_rx_mdata),
    .c0_rx_data      (c0_rx_data),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .outstanding_any (outstanding_any),
    .err_sticky      (err_sticky),
    .stat_issued     (stat_issued),
    .stat_stall      (stat_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [41:0] addr;
    logic [15:0] mdata;
  } tx_t;

  typedef struct {
    logic [3:0]   oh;
    logic [511:0] data;
  } rs_t;

  tx_t tx_q[$];
  rs_t rs_q[$];

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_grant = 0;
  int n_stall = 0;
  int seq     = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [41:0] addr_of(input int i);
    return 42'h123 + (42'(i) << 12);
  endfunction

  function automatic logic [511:0] pat(input int k);
    return {16{32'hC0DE_0000 + 32'(k)}};
  endfunction

  // One cycle of stimulus; rdy is the hand-computed req_ready
  task automatic step(input logic [3:0] v, input logic af,
                      input logic [3:0] rdy, input string nm,
                      input logic rxv = 1'b0,
                      input logic [15:0] rxmd = 16'h0,
                      input logic [511:0] rxd = '0,
                      input logic rxok = 1'b0);
    @(negedge clk);
    req_valid      = v;
    c0_tx_almfull  = af;
    c0_rx_rd_valid = rxv;
    c0_rx_mdata    = rxmd;
    c0_rx_data     = rxd;
    if (af && v != 4'b0) n_stall++;
    #1;
    chk(nm, 64'(req_ready), 64'(rdy));
    for (int i = 0; i < NR; i++) begin
      if (rdy[i]) begin
        tx_q.push_back('{addr_of(i), 16'(i)});
        n_grant++;
      end
    end
    if (rxok) rs_q.push_back('{4'b0001 << rxmd[1:0], rxd});
  endtask

  task automatic drain(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      seq++;
      step(4'b0, 1'b0, 4'b0, "drain", 1'b1, 16'(id), pat(seq), 1'b1);
    end
  endtask

  always @(negedge clk) begin
    tx_t e;
    rs_t r;
    if (!rst) begin
      if (c0_tx_valid) begin
        n_cmp++;
        if (tx_q.size() == 0) begin
          n_bad++;
          $display("FAIL tx_unexpected: got addr %0h mdata %0h want none",
                   c0_tx_addr, c0_tx_mdata);
        end else begin
          e = tx_q.pop_front();
          if (c0_tx_addr !== e.addr || c0_tx_mdata !== e.mdata) begin
            n_bad++;
            $display("FAIL tx: got addr %0h mdata %0h want addr %0h mdata %0h",
                     c0_tx_addr, c0_tx_mdata, e.addr, e.mdata);
          end
        end
      end
      if (rsp_valid != '0) begin
        n_cmp++;
        if (rs_q.size() == 0) begin
          n_bad++;
          $display("FAIL rsp_unexpected: got %b want none", rsp_valid);
        end else begin
          r = rs_q.pop_front();
          if (rsp_valid !== r.oh || rsp_data !== r.data) begin
            n_bad++;
            $display("FAIL rsp: got %b data %0h want %b data %0h",
                     rsp_valid, rsp_data[31:0], r.oh, r.data[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    req_valid      = 4'b1111;
    c0_tx_almfull  = 1'b0;
    c0_rx_rd_valid = 1'b0;
    c0_rx_mdata    = '0;
    c0_rx_data     = '0;
    for (int i = 0; i < NR; i++) req_addr[i*42 +: 42] = addr_of(i);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_tx_valid", 64'(c0_tx_valid), 64'h0);
    chk("rst_tx_addr", 64'(c0_tx_addr), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_oa", 64'(outstanding_any), 64'h0);
    chk("rst_err", 64'(err_sticky), 64'h0);
    chk("rst_issued", 64'(stat_issued), 64'h0);
    chk("rst_stall", 64'(stat_stall), 64'h0);
    req_valid = 4'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single requester, then its response
    step(4'b0001, 1'b0, 4'b0001, "t1_grant");
    step(4'b0000, 1'b0, 4'b0000, "t1_idle");
    seq++;
    step(4'b0000, 1'b0, 4'b0000, "t1_rsp", 1'b1, 16'h0, pat(seq), 1'b1);
    chk("oa_set", 64'(outstanding_any), 64'h1);
    step(4'b0000, 1'b0, 4'b0000, "idle");
    step(4'b0000, 1'b0, 4'b0000, "idle");
    chk("oa_clear", 64'(outstanding_any), 64'h0);

    // Move pointer back to 0, then full round robin
    step(4'b1000, 1'b0, 4'b1000, "ptr_to0");
    for (int k = 0; k < 8; k++)
      step(4'b1111, 1'b0, 4'b0001 << (k % 4), "rr_all");
    drain(0, 2);
    drain(1, 2);
    drain(2, 2);
    drain(3, 3);

    // Almost-full stall with pointer at 2
    step(4'b0010, 1'b0, 4'b0010, "ptr_to2");
    for (int k = 0; k < 5; k++)
      step(4'b1100, 1'b1, 4'b0000, "almfull");
    step(4'b1100, 1'b0, 4'b0100, "af_rel_2");
    step(4'b1100, 1'b0, 4'b1000, "af_rel_3");
    drain(1, 1);
    drain(2, 1);
    drain(3, 1);

    // Requester 1 fills MAX_OUTSTANDING, stalls, resumes after a response
    for (int k = 0; k < MO; k++)
      step(4'b0010, 1'b0, 4'b0010, "fill1");
    step(4'b0010, 1'b0, 4'b0000, "full1_stall");
    step(4'b0010, 1'b0, 4'b0000, "full1_rsp", 1'b1, 16'h0001,
         {64{8'hAB}}, 1'b1);
    step(4'b0010, 1'b0, 4'b0010, "full1_resume");
    drain(1, MO);

    // Bad responses are dropped and latch err_sticky
    chk("err_before", 64'(err_sticky), 64'h0);
    step(4'b0100, 1'b0, 4'b0100, "hi_setup");
    step(4'b0000, 1'b0, 4'b0000, "err_hi", 1'b1, 16'h8002, pat(99), 1'b0);
    step(4'b0000, 1'b0, 4'b0000, "idle");
    chk("err_set", 64'(err_sticky), 64'h1);
    step(4'b0000, 1'b0, 4'b0000, "err_id7", 1'b1, 16'h0007, pat(98), 1'b0);
    step(4'b0000, 1'b0, 4'b0000, "err_zero", 1'b1, 16'h0000, pat(97), 1'b0);
    drain(2, 1);

    // Grant and response on the same requester leave outst unchanged
    for (int k = 0; k < 3; k++)
      step(4'b0001, 1'b0, 4'b0001, "fill0");
    seq++;
    step(4'b0001, 1'b0, 4'b0001, "sim_grant_rsp", 1'b1, 16'h0000,
         pat(seq), 1'b1);
    step(4'b0001, 1'b0, 4'b0001, "sim_post");
    step(4'b0001, 1'b0, 4'b0000, "sim_full");
    drain(0, MO);
    step(4'b0000, 1'b0, 4'b0000, "idle");
    step(4'b0000, 1'b0, 4'b0000, "idle");
    chk("oa_final", 64'(outstanding_any), 64'h0);
    step(4'b0000, 1'b0, 4'b0000, "idle");
    chk("tx_q_drained", 64'(tx_q.size()), 64'h0);
    chk("rs_q_drained", 64'(rs_q.size()), 64'h0);
    chk("err_held", 64'(err_sticky), 64'h1);
`ifdef CCIP_RD_ARBITER_STATS_EN
    chk("stat_issued", 64'(stat_issued), 64'(n_grant));
    chk("stat_stall", 64'(stat_stall), 64'(n_stall));
`else
    chk("stat_issued", 64'(stat_issued), 64'h0);
    chk("stat_stall", 64'(stat_stall), 64'h0);
`endif

    // Reset clears the sticky error
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rerst_err", 64'(err_sticky), 64'h0);
    chk("rerst_tx", 64'(c0_tx_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
